// File: rtl/bpsk_pkg.sv
// Shared types, constants and saturating negate for the BPSK transmit path.
`ifndef FIXDT_64_WIDTH
`define FIXDT_64_WIDTH 16
`endif
`ifndef CARRIER_SAMPLES_PER_PERIOD
`define CARRIER_SAMPLES_PER_PERIOD 64
`endif

package bpsk_pkg;
  localparam int FIXDT_W     = `FIXDT_64_WIDTH;
  localparam int CARRIER_SPP = `CARRIER_SAMPLES_PER_PERIOD;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} tx_state_t;
  typedef logic signed [`FIXDT_64_WIDTH-1:0] fixdt64_t;

  localparam fixdt64_t FIXDT_MIN = {1'b1, {(FIXDT_W-1){1'b0}}};
  localparam fixdt64_t FIXDT_MAX = {1'b0, {(FIXDT_W-1){1'b1}}};

  // The most negative code has no positive twin, so it clips to full scale.
  function automatic fixdt64_t sat_neg(input fixdt64_t x);
    fixdt64_t r;
    if (x == FIXDT_MIN) begin
      r = FIXDT_MAX;
    end else begin
      r = -x;
    end
    return r;
  endfunction
endpackage

// File: rtl/bpsk_tx_modulator_lut.sv
// cosine_lut: combinational full-wave cosine built from a 64-point quarter-wave table.
module cosine_lut
  import bpsk_pkg::*;
#(
  parameter int SPP        = CARRIER_SPP,
  parameter int READ_PORTS = 1,
  localparam int AW        = $clog2(SPP)
) (
  input  logic [READ_PORTS*AW-1:0]      idx_i,
  output logic [READ_PORTS*FIXDT_W-1:0] data_o
);
  // Table resolution is 64 points per period; coarser carriers step through it.
  localparam int SHIFT = 6 - AW;

  localparam fixdt64_t QTR [0:16] = '{
    16'sd32767, 16'sd32609, 16'sd32137, 16'sd31356, 16'sd30273, 16'sd28898,
    16'sd27245, 16'sd25329, 16'sd23170, 16'sd20787, 16'sd18204, 16'sd15446,
    16'sd12539, 16'sd9512,  16'sd6393,  16'sd3212,  16'sd0
  };

  function automatic fixdt64_t cos_at(input logic [5:0] i);
    logic [3:0] r;
    fixdt64_t   v;
    r = i[3:0];
    case (i[5:4])
      2'd0:    v = QTR[r];
      2'd1:    v = -QTR[5'd16 - {1'b0, r}];
      2'd2:    v = -QTR[r];
      default: v = QTR[5'd16 - {1'b0, r}];
    endcase
    return v;
  endfunction

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    assign data_o[p*FIXDT_W +: FIXDT_W] = cos_at(6'(idx_i[p*AW +: AW]) << SHIFT);
  end
endmodule

// File: rtl/bpsk_tx_modulator.sv
// BPSK transmit modulator: one bit per PPB carrier periods, sign-flipped cosine samples
// emitted on each DAC strobe, continuous zero samples while idle.
module bpsk_tx_modulator
  import bpsk_pkg::*;
#(
  parameter int SPP    = CARRIER_SPP,
  parameter int PPB    = 4,
  parameter int DATA_W = FIXDT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample_en,
  input  logic                     bit_valid,
  input  logic                     bit_in,
  output logic                     bit_ready,
  output logic signed [DATA_W-1:0] sample_out,
  output logic                     sample_valid,
  output logic                     busy
);
  localparam int PW = $clog2(SPP);
  localparam int CW = (PPB > 1) ? $clog2(PPB) : 1;
  localparam logic [PW-1:0] PHASE_LAST  = PW'(SPP - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(PPB - 1);

  tx_state_t     state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [CW-1:0] period_q, period_d;
  logic          cur_bit_q, cur_bit_d;
  fixdt64_t      sample_q, sample_d;
  logic          sample_valid_q, busy_q, busy_d;
  logic [FIXDT_W-1:0] lut_raw_s;
  fixdt64_t      lut_s;
  logic          last_smp_s, accept_s;

  cosine_lut #(.SPP(SPP), .READ_PORTS(1)) u_lut (
    .idx_i  (phase_q),
    .data_o (lut_raw_s)
  );
  assign lut_s = lut_raw_s;

  assign last_smp_s = (state_q == SEND) && (phase_q == PHASE_LAST) && (period_q == PERIOD_LAST);
  assign bit_ready  = (state_q == IDLE) || (sample_en && last_smp_s);
  assign accept_s   = bit_valid && bit_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept_s ? SEND : IDLE;
      SEND:    state_d = (sample_en && last_smp_s && !accept_s) ? IDLE : SEND;
      default: state_d = IDLE;
    endcase
  end

  // A back-to-back bit at the symbol end lets the counters wrap naturally: no gap sample.
  always_comb begin
    phase_d   = phase_q;
    period_d  = period_q;
    cur_bit_d = accept_s ? bit_in : cur_bit_q;
    sample_d  = sample_q;
    busy_d    = (state_d == SEND);
    if (state_q == IDLE) begin
      if (accept_s) begin
        phase_d  = '0;
        period_d = '0;
      end else begin
        phase_d  = phase_q;
      end
      if (sample_en) begin
        sample_d = '0;
      end else begin
        sample_d = sample_q;
      end
    end else if (sample_en) begin
      sample_d = cur_bit_q ? sat_neg(lut_s) : lut_s;
      if (phase_q == PHASE_LAST) begin
        phase_d  = '0;
        period_d = (period_q == PERIOD_LAST) ? '0 : period_q + 1'b1;
      end else begin
        phase_d  = phase_q + 1'b1;
      end
    end else begin
      sample_d = sample_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q        <= '0;
      period_q       <= '0;
      cur_bit_q      <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      period_q       <= period_d;
      cur_bit_q      <= cur_bit_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_en;
      busy_q         <= busy_d;
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = sample_valid_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_bpsk_tx_modulator.sv
// Directed bench for bpsk_tx_modulator (SPP=64, PPB=2); expected carrier from $cos.
module tb_bpsk_tx_modulator;
  import bpsk_pkg::*;

  localparam int SPP = 64;
  localparam int PPB = 2;
  localparam int SYM = SPP * PPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sample_en = 1'b0;
  logic bit_valid = 1'b0;
  logic bit_in = 1'b0;
  logic bit_ready;
  logic signed [15:0] sample_out;
  logic sample_valid;
  logic busy;

  int n_cmp = 0;
  int n_bad = 0;

  bpsk_tx_modulator #(.SPP(SPP), .PPB(PPB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_en    (sample_en),
    .bit_valid    (bit_valid),
    .bit_in       (bit_in),
    .bit_ready    (bit_ready),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_cos(input int k);
    real v;
    v = 32767.0 * $cos(2.0 * 3.14159265358979 * real'(k % SPP) / real'(SPP));
    if (v >= 0.0) return $rtoi(v + 0.5);
    else return -$rtoi(-v + 0.5);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_symbol(input logic b, input string tag);
    int busy_cnt;
    bit_valid = 1'b1;
    bit_in    = b;
    sample_en = 1'b1;
    #1 chk({tag, "_rdy_idle"}, bit_ready, 1);
    tick;
    bit_valid = 1'b0;
    chk({tag, "_busy_acc"}, busy, 1);
    chk({tag, "_idle_smp"}, sample_out, 0);
    busy_cnt = 1;
    for (int k = 0; k < SYM; k++) begin
      tick;
      chk({tag, "_valid"}, sample_valid, 1);
      chk({tag, "_smp"}, sample_out, b ? -exp_cos(k) : exp_cos(k));
      if (busy) busy_cnt++;
    end
    chk({tag, "_busy_len"}, busy_cnt, SYM);
    tick;
    chk({tag, "_tail_zero"}, sample_out, 0);
    chk({tag, "_tail_valid"}, sample_valid, 1);
  endtask

  initial begin
    int s;
    int exp_last;
    logic en_prev;
    logic [2:0] bits;

    // reset state
    #12;
    chk("rst_smp", sample_out, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", bit_ready, 1);
    rst_n = 1'b1;
    tick;

    // bit 0 and bit 1 symbols
    send_symbol(1'b0, "t2");
    send_symbol(1'b1, "t3");
    chk("sat_min", sat_neg(16'sh8000), 32767);
    chk("sat_max", sat_neg(16'sh7FFF), -32767);
    chk("sat_five", sat_neg(16'sd5), -5);

    // back-to-back bits 0,1,1 with bit_valid held
    bits = 3'b110;
    bit_valid = 1'b1;
    bit_in    = bits[0];
    sample_en = 1'b1;
    tick;
    bit_in = bits[1];
    for (int k = 0; k < 3 * SYM; k++) begin
      chk("t4_rdy", bit_ready, (k % SYM) == (SYM - 1));
      tick;
      chk("t4_valid", sample_valid, 1);
      chk("t4_smp", sample_out, bits[k / SYM] ? -exp_cos(k) : exp_cos(k));
      if (k == 2 * SYM - 1) bit_valid = 1'b0;
    end
    chk("t4_busy_end", busy, 0);
    tick;
    chk("t4_tail_zero", sample_out, 0);

    // strobe every 3rd cycle, new bit offered mid-symbol
    sample_en = 1'b0;
    bit_valid = 1'b1;
    bit_in    = 1'b0;
    #1 chk("t5_rdy_idle", bit_ready, 1);
    tick;
    bit_valid = 1'b0;
    chk("t5_busy", busy, 1);
    chk("t5_novalid", sample_valid, 0);
    exp_last = 0;
    s = 0;
    for (int c = 0; c < 2000 && s < 2 * SYM; c++) begin
      sample_en = ((c % 3) == 2);
      if (s >= 50 && s < SYM) begin
        bit_valid = 1'b1;
        bit_in    = 1'b1;
      end else begin
        bit_valid = 1'b0;
      end
      #1 chk("t5_rdy", bit_ready, sample_en && ((s % SYM) == (SYM - 1)));
      en_prev = sample_en;
      tick;
      chk("t5_valid", sample_valid, en_prev);
      if (en_prev) begin
        exp_last = (s < SYM) ? exp_cos(s) : -exp_cos(s);
        s++;
      end
      chk("t5_smp", sample_out, exp_last);
    end
    chk("t5_strobes", s, 2 * SYM);
    sample_en = 1'b0;
    tick;
    chk("t5_busy_end", busy, 0);

    // async reset at phase_idx=37, then a fresh symbol restarts at lut[0]
    sample_en = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b0;
    tick;
    bit_valid = 1'b0;
    for (int k = 0; k < 37; k++) tick;
    chk("t6_pre_rst", sample_out, exp_cos(36));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_smp", sample_out, 0);
    chk("t6_rst_valid", sample_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_rdy", bit_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk("t6_idle_smp", sample_out, 0);
    bit_valid = 1'b1;
    tick;
    bit_valid = 1'b0;
    tick;
    chk("t6_first", sample_out, exp_cos(0));
    tick;
    chk("t6_second", sample_out, exp_cos(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
